// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift, rotate, load and clear, applied
// either directly each cycle or as an automatic N-step burst with busy/done.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_count,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] q_d;
    logic [CNT_W-1:0] rem, rem_d;
    logic [2:0]       bmode, bmode_d;
    logic             is_burst_mode;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        apply_op = v;
        case (op)
            3'b001:  apply_op = {v[WIDTH-2:0], sr};
            3'b010:  apply_op = {sl, v[WIDTH-1:1]};
            3'b011:  apply_op = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b100:  apply_op = {v[0], v[WIDTH-1:1]};
            3'b101:  apply_op = ld;
            3'b110:  apply_op = '0;
            default: apply_op = v;
        endcase
    endfunction

    // Only the four shift/rotate modes may be run as a burst.
    assign is_burst_mode = (mode >= 3'b001) && (mode <= 3'b100);

    always_comb begin
        state_d = state;
        q_d     = q;
        rem_d   = rem;
        bmode_d = bmode;
        case (state)
            S_RUN: begin
                q_d   = apply_op(bmode, q, load_data, ser_in_l, ser_in_r);
                rem_d = rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                // IDLE and DONE accept a new command the same way.
                if (start && is_burst_mode) begin
                    bmode_d = mode;
                    if (shift_count != '0) begin
                        q_d     = apply_op(mode, q, load_data, ser_in_l, ser_in_r);
                        rem_d   = shift_count - CNT_W'(1);
                        state_d = (shift_count > CNT_W'(1)) ? S_RUN : S_DONE;
                    end else begin
                        rem_d   = '0;
                        state_d = S_DONE;
                    end
                end else begin
                    q_d     = apply_op(mode, q, load_data, ser_in_l, ser_in_r);
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            q     <= '0;
            rem   <= '0;
            bmode <= 3'b000;
        end else begin
            state <= state_d;
            q     <= q_d;
            rem   <= rem_d;
            bmode <= bmode_d;
        end
    end

    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed vector table, hand-written burst corner
// cases and random traffic, all checked against a step-counting reference model.
module tb_universal_shift_reg;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int MODV  = 1 << W;
    localparam int HALF  = MODV / 2;

    logic          clk;
    logic          rst;
    logic [2:0]    mode;
    logic [W-1:0]  load_data;
    logic          start;
    logic [CW-1:0] shift_count;
    logic          ser_in_l;
    logic          ser_in_r;
    logic [W-1:0]  q;
    logic          ser_out_l;
    logic          ser_out_r;
    logic          busy;
    logic          done;

    universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .load_data   (load_data),
        .start       (start),
        .shift_count (shift_count),
        .ser_in_l    (ser_in_l),
        .ser_in_r    (ser_in_r),
        .q           (q),
        .ser_out_l   (ser_out_l),
        .ser_out_r   (ser_out_r),
        .busy        (busy),
        .done        (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: value, steps still owed by the burst, done flag
    int m_q    = 0;
    int m_left = 0;
    int m_done = 0;
    int m_bmode = 0;

    logic [W-1:0] exp_q[$];

    function automatic int ref_op(input int op, input int v, input int ld, input int sl, input int sr);
        case (op)
            1:       return (v * 2) % MODV + sr;
            2:       return v / 2 + sl * HALF;
            3:       return (v * 2) % MODV + v / HALF;
            4:       return v / 2 + (v % 2) * HALF;
            5:       return ld;
            6:       return 0;
            default: return v;
        endcase
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // driver: apply one set of inputs across one rising edge, update model, compare
    task automatic cycle(input logic r, input logic [2:0] m, input logic s, input logic [CW-1:0] n,
                         input logic [W-1:0] ld, input logic sl, input logic sr);
        logic [W-1:0] e;
        rst = r; mode = m; start = s; shift_count = n; load_data = ld; ser_in_l = sl; ser_in_r = sr;
        @(posedge clk);
        if (r) begin
            m_q = 0; m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            m_q = ref_op(m_bmode, m_q, ld, sl, sr);
            m_left--;
            m_done = (m_left == 0);
        end else if (s && m >= 1 && m <= 4) begin
            m_bmode = m;
            if (n == 0) begin
                m_done = 1;
            end else begin
                m_q = ref_op(m, m_q, ld, sl, sr);
                m_left = n - 1;
                m_done = (m_left == 0);
            end
        end else begin
            m_q = ref_op(m, m_q, ld, sl, sr);
            m_done = 0;
        end
        exp_q.push_back(W'(m_q));
        @(negedge clk);
        e = exp_q.pop_front();
        check("model_q", q, e);
        check("model_busy", busy, m_left > 0);
        check("model_done", done, m_done);
        check("ser_out_l", ser_out_l, e[W-1]);
        check("ser_out_r", ser_out_r, e[0]);
    endtask

    typedef struct {
        logic          r;
        logic [2:0]    m;
        logic          s;
        logic [CW-1:0] n;
        logic [W-1:0]  ld;
        logic          sl;
        logic          sr;
        logic [W-1:0]  eq;
        logic          eb;
        logic          ed;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int busy_cnt;
        int done_cnt;
        logic [7:0] bits;

        rst = 1'b1; mode = 3'b000; start = 1'b0; shift_count = '0;
        load_data = '0; ser_in_l = 1'b0; ser_in_r = 1'b0;
        @(negedge clk);

        //            r     m       s     n      ld     sl    sr    eq     eb    ed
        vecs[0]  = '{1'b1, 3'b000, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'b101, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'b011, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b100, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h4B, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'b010, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h25, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'b110, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3'b111, 1'b0, 4'd0, 8'h3C, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'b000, 1'b0, 4'd0, 8'h3C, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 3'b100, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 3'b110, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 3'b000, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].r, vecs[i].m, vecs[i].s, vecs[i].n, vecs[i].ld, vecs[i].sl, vecs[i].sr);
            check($sformatf("vec%0d_q", i), q, vecs[i].eq);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
            check($sformatf("vec%0d_done", i), done, vecs[i].ed);
        end

        // N=0: no change, done next cycle, never busy
        cycle(0, 3'b101, 0, 0, 8'h5A, 0, 0);
        cycle(0, 3'b001, 1, 0, 8'h00, 0, 1);
        check("n0_q", q, 8'h5A);
        check("n0_done", done, 1);
        cycle(0, 3'b000, 0, 0, 8'h00, 0, 0);
        check("n0_done_clear", done, 0);

        // N=1: single step, done next cycle
        cycle(0, 3'b100, 1, 1, 8'h00, 0, 0);
        check("n1_q", q, 8'h2D);
        check("n1_busy", busy, 0);
        check("n1_done", done, 1);

        // N=15: busy for 14 cycles, done once
        busy_cnt = 0; done_cnt = 0;
        cycle(0, 3'b011, 1, 15, 8'h00, 0, 0);
        if (busy) busy_cnt++;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 3'b110, 0, 0, 8'h00, 0, 0);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("n15_busy_cycles", busy_cnt, 14);
        check("n15_done_cycles", done_cnt, 1);

        // reset mid-burst aborts without a done pulse
        cycle(0, 3'b101, 0, 0, 8'hF0, 0, 0);
        cycle(0, 3'b011, 1, 8, 8'h00, 0, 0);
        cycle(0, 3'b000, 0, 0, 8'h00, 0, 0);
        cycle(0, 3'b000, 0, 0, 8'h00, 0, 0);
        cycle(1, 3'b000, 0, 0, 8'h00, 0, 0);
        check("abort_q", q, 8'h00);
        check("abort_busy", busy, 0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 3'b000, 0, 0, 8'h00, 0, 0);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // start with load mode is a plain load
        cycle(0, 3'b101, 1, 4, 8'h77, 0, 0);
        check("start_load_q", q, 8'h77);
        check("start_load_busy", busy, 0);
        check("start_load_done", done, 0);

        // serial shift-left burst, then back-to-back start while done
        bits = 8'b1011_0010;
        cycle(0, 3'b110, 0, 0, 8'h00, 0, 0);
        cycle(0, 3'b001, 1, 8, 8'h00, 0, bits[7]);
        for (int i = 6; i >= 0; i--) begin
            cycle(0, 3'b000, 0, 0, 8'h00, 0, bits[i]);
        end
        check("serial_q", q, 8'hB2);
        check("serial_done", done, 1);
        cycle(0, 3'b100, 1, 3, 8'h00, 0, 0);
        check("b2b_busy", busy, 1);
        check("b2b_q", q, 8'h59);
        cycle(0, 3'b000, 0, 0, 8'h00, 0, 0);
        cycle(0, 3'b000, 0, 0, 8'h00, 0, 0);
        check("b2b_done", done, 1);
        check("b2b_final_q", q, 8'h56);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0),
                  CW'($urandom_range(0, 15)),
                  W'($urandom),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
